datapath_chain_sequencer: RTL and testbench

Command-driven sequencer for cpu_alu_datapath. It accepts one "chain" command over a valid/ready handshake. It then issues 1..16 consecutive register-file ALU operations: R[dst+i] <= R[srcA+i] op R[srcB+i], with all indices taken mod 16. It drives the datapath's regEnable, ctrlA, ctrlB and inst inputs in place of a hard-coded per-program FSM, and reports busy/done to the top level.

---
 rtl/datapath_chain_sequencer_pkg.sv | 26 ++
 rtl/datapath_chain_sequencer_if.sv | 41 ++++
 rtl/datapath_chain_sequencer_reg_onehot_dec.sv | 15 +
 rtl/datapath_chain_sequencer.sv | 106 ++++++++++
 tb/tb_datapath_chain_sequencer.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/datapath_chain_sequencer_pkg.sv
// Shared types and constants for the ALU chain sequencer.
// Imported by the interface, decoder and top.
package datapath_chain_sequencer_pkg;

  localparam int NREG   = 16;
  localparam int IDX_W  = 4;
  localparam int INST_W = 16;

  localparam logic [INST_W-1:0] INST_NOP = 16'h0000;

  typedef logic [IDX_W-1:0] idx_t;

  typedef enum logic [1:0] {
    IDLE,
    STEP,
    DONE
  } state_e;

  typedef struct packed {
    idx_t dst;
    idx_t srca;
    idx_t srcb;
    idx_t count;
  } cmd_t;

endpackage

// File: rtl/datapath_chain_sequencer_if.sv
// Command handshake plus datapath control bundle.
// master = command source / datapath, slave = sequencer.
interface datapath_chain_sequencer_if;
  import datapath_chain_sequencer_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [INST_W-1:0] cmd_inst;
  idx_t              cmd_dst;
  idx_t              cmd_srca;
  idx_t              cmd_srcb;
  idx_t              cmd_count;
  logic              hold;

  logic [NREG-1:0]   regEnable;
  idx_t              ctrlA;
  idx_t              ctrlB;
  logic [INST_W-1:0] inst;
  logic              busy;
  logic              done;
  idx_t              step_idx;

  modport master (
    output cmd_valid, cmd_inst, cmd_dst,
    output cmd_srca, cmd_srcb, cmd_count,
    output hold,
    input  cmd_ready, regEnable, ctrlA,
    input  ctrlB, inst, busy, done,
    input  step_idx
  );

  modport slave (
    input  cmd_valid, cmd_inst, cmd_dst,
    input  cmd_srca, cmd_srcb, cmd_count,
    input  hold,
    output cmd_ready, regEnable, ctrlA,
    output ctrlB, inst, busy, done,
    output step_idx
  );

endinterface

// File: rtl/datapath_chain_sequencer_reg_onehot_dec.sv
// Register index to one-hot write-enable decoder.
// Purely combinational.
module reg_onehot_dec
  import datapath_chain_sequencer_pkg::*;
(
  input  idx_t            idx_i,
  output logic [NREG-1:0] onehot_o
);

  always_comb begin
    onehot_o        = '0;
    onehot_o[idx_i] = 1'b1;
  end

endmodule

// File: rtl/datapath_chain_sequencer.sv
// Issues 1..16 chained R[dst+i] <= R[srca+i] op R[srcb+i]
// operations to the ALU datapath from one command.
module datapath_chain_sequencer
  import datapath_chain_sequencer_pkg::*;
(
  input logic clk,
  input logic reset,
  datapath_chain_sequencer_if.slave bus
);

  state_e            state_q;
  cmd_t              cmd_q;
  logic [NREG-1:0]   regen_q;
  idx_t              ctrla_q;
  idx_t              ctrlb_q;
  idx_t              idx_q;
  logic [INST_W-1:0] inst_q;
  logic              busy_q;
  logic              done_q;

  logic            accept;
  logic            wrote;
  logic            last_d;
  idx_t            nxt_d;
  idx_t            dec_d;
  logic [NREG-1:0] onehot;

  assign bus.cmd_ready = reset && (state_q == IDLE);
  assign accept = bus.cmd_valid && bus.cmd_ready;

  // A held cycle leaves the pending iteration unwritten,
  // so the index only advances after a real write.
  assign wrote  = (regen_q != '0);
  assign last_d = wrote && (idx_q == cmd_q.count);
  assign nxt_d  = wrote ? idx_q + idx_t'(1) : idx_q;

  assign dec_d = (state_q == IDLE) ? bus.cmd_dst
                                   : cmd_q.dst + nxt_d;

  reg_onehot_dec u_dec (
    .idx_i    (dec_d),
    .onehot_o (onehot)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      regen_q <= '0;
      ctrla_q <= '0;
      ctrlb_q <= '0;
      idx_q   <= '0;
      inst_q  <= INST_NOP;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          regen_q <= '0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          if (accept) begin
            state_q <= STEP;
            cmd_q   <= '{dst:   bus.cmd_dst,
                         srca:  bus.cmd_srca,
                         srcb:  bus.cmd_srcb,
                         count: bus.cmd_count};
            regen_q <= onehot;
            ctrla_q <= bus.cmd_srca;
            ctrlb_q <= bus.cmd_srcb;
            inst_q  <= bus.cmd_inst;
            idx_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        STEP: begin
          if (last_d) begin
            state_q <= DONE;
            regen_q <= '0;
            done_q  <= 1'b1;
          end else begin
            idx_q   <= nxt_d;
            ctrla_q <= cmd_q.srca + nxt_d;
            ctrlb_q <= cmd_q.srcb + nxt_d;
            regen_q <= bus.hold ? '0 : onehot;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.regEnable = regen_q;
  assign bus.ctrlA     = ctrla_q;
  assign bus.ctrlB     = ctrlb_q;
  assign bus.inst      = inst_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.step_idx  = idx_q;

endmodule

// File: tb/tb_datapath_chain_sequencer.sv
// Randomized and directed checks of the chain sequencer
// against a write-list reference model.
module tb_datapath_chain_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_pass = 0;

  logic [15:0] n_inst;
  int n_d, n_sa, n_sb, n_c;

  datapath_chain_sequencer_if bus ();

  datapath_chain_sequencer dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h",
                  tag, got, exp);
  endtask

  // Called at a negedge; returns at a negedge in IDLE.
  task automatic chain(input logic [15:0] ci,
                       input int d, sa, sb, c,
                       input int hat, hlen, abort,
                       input bit keep);
    int i = 0;
    int held = 0;
    int cyc = 0;
    bit fin = 0;
    bus.cmd_inst  = ci;
    bus.cmd_dst   = 4'(d);
    bus.cmd_srca  = 4'(sa);
    bus.cmd_srcb  = 4'(sb);
    bus.cmd_count = 4'(c);
    bus.cmd_valid = 1'b1;
    chk("rdy", 32'(bus.cmd_ready), 1);
    @(posedge clk);
    #1;
    if (keep) begin
      bus.cmd_inst  = n_inst;
      bus.cmd_dst   = 4'(n_d);
      bus.cmd_srca  = 4'(n_sa);
      bus.cmd_srcb  = 4'(n_sb);
      bus.cmd_count = 4'(n_c);
    end else begin
      bus.cmd_valid = 1'b0;
    end
    while (!fin && cyc < 80) begin
      @(negedge clk);
      cyc++;
      if (bus.done) begin
        chk("done_n", 32'(i), 32'(c + 1));
        chk("done_lat", 32'(cyc), 32'(c + 2 + hlen));
        chk("done_we", 32'(bus.regEnable), 0);
        chk("done_busy", 32'(bus.busy), 1);
        chk("done_rdy", 32'(bus.cmd_ready), 0);
        chk("done_ca", 32'(bus.ctrlA), 32'((sa + c) & 15));
        chk("done_cb", 32'(bus.ctrlB), 32'((sb + c) & 15));
        chk("done_inst", 32'(bus.inst), 32'(ci));
        fin = 1;
      end else if (bus.regEnable != 0) begin
        chk("we", 32'(bus.regEnable), 1 << ((d + i) & 15));
        chk("ca", 32'(bus.ctrlA), 32'((sa + i) & 15));
        chk("cb", 32'(bus.ctrlB), 32'((sb + i) & 15));
        chk("inst", 32'(bus.inst), 32'(ci));
        chk("idx", 32'(bus.step_idx), 32'(i));
        chk("busy", 32'(bus.busy), 1);
        chk("nrdy", 32'(bus.cmd_ready), 0);
        chk("wr_n", 32'(i <= c), 1);
        if (abort >= 0 && i == abort) begin
          rst_n = 1'b0;
          @(negedge clk);
          chk("rst_we", 32'(bus.regEnable), 0);
          chk("rst_busy", 32'(bus.busy), 0);
          chk("rst_done", 32'(bus.done), 0);
          chk("rst_ca", 32'(bus.ctrlA), 0);
          chk("rst_cb", 32'(bus.ctrlB), 0);
          chk("rst_inst", 32'(bus.inst), 0);
          chk("rst_idx", 32'(bus.step_idx), 0);
          chk("rst_rdy0", 32'(bus.cmd_ready), 0);
          rst_n = 1'b1;
          #1;
          chk("rst_rdy1", 32'(bus.cmd_ready), 1);
          repeat (4) begin
            @(negedge clk);
            chk("rst_nodone", 32'(bus.done | bus.busy), 0);
          end
          return;
        end
        if (hlen > 0 && i == hat - 1) bus.hold = 1'b1;
        i++;
      end else begin
        held++;
        chk("hold_cnt", 32'(held <= hlen), 1);
        chk("hold_idx", 32'(bus.step_idx), 32'(i));
        chk("hold_busy", 32'(bus.busy), 1);
        if (held == hlen) bus.hold = 1'b0;
      end
    end
    if (!fin) begin
      chk("timeout", 32'(cyc), 0);
      bus.hold = 1'b0;
      return;
    end
    @(negedge clk);
    chk("idle_done", 32'(bus.done), 0);
    chk("idle_busy", 32'(bus.busy), 0);
    chk("idle_rdy", 32'(bus.cmd_ready), 1);
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_inst  = '0;
    bus.cmd_dst   = '0;
    bus.cmd_srca  = '0;
    bus.cmd_srcb  = '0;
    bus.cmd_count = '0;
    bus.hold      = 1'b0;
    n_inst = '0;
    n_d = 0; n_sa = 0; n_sb = 0; n_c = 0;

    bus.cmd_valid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("r_we", 32'(bus.regEnable), 0);
    chk("r_ca", 32'(bus.ctrlA), 0);
    chk("r_cb", 32'(bus.ctrlB), 0);
    chk("r_inst", 32'(bus.inst), 0);
    chk("r_busy", 32'(bus.busy), 0);
    chk("r_done", 32'(bus.done), 0);
    chk("r_idx", 32'(bus.step_idx), 0);
    chk("r_rdy", 32'(bus.cmd_ready), 0);
    bus.cmd_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("r_rdy1", 32'(bus.cmd_ready), 1);
    @(negedge clk);

    chain(16'h0090, 2, 0, 1, 12, 0, 0, -1, 1'b0);
    chain(16'h00a1, 14, 15, 0, 3, 0, 0, -1, 1'b0);
    chain(16'h0033, 6, 1, 9, 4, 2, 2, -1, 1'b0);

    n_inst = 16'h5a5a;
    n_d = 9; n_sa = 11; n_sb = 13; n_c = 2;
    chain(16'h1234, 3, 7, 8, 5, 0, 0, -1, 1'b1);
    chain(n_inst, n_d, n_sa, n_sb, n_c, 0, 0, -1, 1'b0);

    chain(16'h0777, 1, 2, 3, 8, 0, 0, 3, 1'b0);
    chain(16'h0042, 5, 3, 4, 0, 0, 0, -1, 1'b0);

    for (int k = 0; k < 25; k++) begin
      int c, hat, hlen;
      c = int'($urandom_range(0, 15));
      hat = 0;
      hlen = 0;
      if (c >= 1 && ($urandom & 1) == 1) begin
        hat  = int'($urandom_range(1, c));
        hlen = int'($urandom_range(1, 3));
      end
      chain(16'($urandom), int'($urandom_range(0, 15)),
            int'($urandom_range(0, 15)),
            int'($urandom_range(0, 15)),
            c, hat, hlen, -1, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
